// File: rtl/pattern_generator.sv
// Serial pattern transmitter: loads a pattern via valid/ready, shifts it out MSB-first one bit per clock,
// repeating frames with optional idle gaps. All outputs registered except LOAD_READY and BUSY.
module pattern_generator #(
  parameter int       WIDTH      = 8,
  parameter int       LEN_W      = 4,
  parameter int       CNT_W      = 4,
  parameter int       GAP_CYCLES = 0,
  parameter logic     IDLE_BIT   = 1'b0
) (
  input  logic             CLK,
  input  logic             RES,
  input  logic             LOAD_VALID,
  output logic             LOAD_READY,
  input  logic [WIDTH-1:0] PATTERN,
  input  logic [LEN_W-1:0] LEN,
  input  logic [CNT_W-1:0] REPEAT,
  input  logic             ABORT,
  output logic             SDO,
  output logic             BIT_VALID,
  output logic             FRAME_START,
  output logic             BUSY,
  output logic             DONE
);

  localparam int GAP_W = $clog2(GAP_CYCLES + 2);
  localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [LEN_W-1:0] WIDTH_L   = LEN_W'(WIDTH);
  localparam logic [LEN_W-1:0] LEN_ONE   = LEN_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   pat_q, pat_d;
  logic [WIDTH-1:0]   sh_q, sh_d;
  logic [LEN_W-1:0]   bit_q, bit_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [CNT_W-1:0]   frm_q, frm_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic               sdo_q, sdo_d;
  logic               bit_vld_q, bit_vld_d;
  logic               frame_start_q, frame_start_d;
  logic               done_q, done_d;

  logic [LEN_W-1:0]   len_c;
  logic [CNT_W-1:0]   rep_c;
  logic [WIDTH-1:0]   aligned;

  assign LOAD_READY  = (state_q == IDLE) && !ABORT;
  assign BUSY        = (state_q != IDLE);
  assign SDO         = sdo_q;
  assign BIT_VALID   = bit_vld_q;
  assign FRAME_START = frame_start_q;
  assign DONE        = done_q;

  always_comb begin
    state_d       = state_q;
    pat_d         = pat_q;
    sh_d          = sh_q;
    bit_d         = bit_q;
    len_d         = len_q;
    frm_d         = frm_q;
    gap_d         = gap_q;
    sdo_d         = IDLE_BIT;
    bit_vld_d     = 1'b0;
    frame_start_d = 1'b0;
    done_d        = 1'b0;

    len_c   = (LEN > WIDTH_L) ? WIDTH_L : LEN;
    rep_c   = (REPEAT == '0) ? CNT_ONE : REPEAT;
    // Left-align so the first bit to send always sits in the MSB.
    aligned = PATTERN << (WIDTH_L - len_c);

    case (state_q)
      IDLE: begin
        if (LOAD_VALID && LOAD_READY) begin
          if (len_c == '0) begin
            done_d = 1'b1;
          end else begin
            pat_d         = aligned;
            len_d         = len_c;
            frm_d         = rep_c;
            bit_d         = len_c - LEN_ONE;
            sdo_d         = aligned[WIDTH-1];
            sh_d          = aligned << 1;
            bit_vld_d     = 1'b1;
            frame_start_d = 1'b1;
            state_d       = SHIFT;
          end
        end
      end
      SHIFT: begin
        if (ABORT) begin
          state_d = IDLE;
        end else if (bit_q != '0) begin
          bit_d     = bit_q - LEN_ONE;
          sdo_d     = sh_q[WIDTH-1];
          sh_d      = sh_q << 1;
          bit_vld_d = 1'b1;
        end else if (frm_q > CNT_ONE) begin
          frm_d = frm_q - CNT_ONE;
          if (GAP_CYCLES > 0) begin
            gap_d   = GAP_LAST;
            state_d = GAP;
          end else begin
            bit_d         = len_q - LEN_ONE;
            sdo_d         = pat_q[WIDTH-1];
            sh_d          = pat_q << 1;
            bit_vld_d     = 1'b1;
            frame_start_d = 1'b1;
          end
        end else begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      GAP: begin
        if (ABORT) begin
          state_d = IDLE;
        end else if (gap_q == '0) begin
          bit_d         = len_q - LEN_ONE;
          sdo_d         = pat_q[WIDTH-1];
          sh_d          = pat_q << 1;
          bit_vld_d     = 1'b1;
          frame_start_d = 1'b1;
          state_d       = SHIFT;
        end else begin
          gap_d = gap_q - GAP_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RES) begin
    if (!RES) begin
      state_q       <= IDLE;
      pat_q         <= '0;
      sh_q          <= '0;
      bit_q         <= '0;
      len_q         <= '0;
      frm_q         <= '0;
      gap_q         <= '0;
      sdo_q         <= IDLE_BIT;
      bit_vld_q     <= 1'b0;
      frame_start_q <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      pat_q         <= pat_d;
      sh_q          <= sh_d;
      bit_q         <= bit_d;
      len_q         <= len_d;
      frm_q         <= frm_d;
      gap_q         <= gap_d;
      sdo_q         <= sdo_d;
      bit_vld_q     <= bit_vld_d;
      frame_start_q <= frame_start_d;
      done_q        <= done_d;
    end
  end

endmodule

// File: tb/tb_pattern_generator.sv
// Directed bench for pattern_generator: one instance with a 2-cycle inter-frame gap, one back-to-back.
module tb_pattern_generator;

  logic       CLK = 1'b0;
  logic       RES = 1'b0;
  logic       LOAD_VALID = 1'b0;
  logic [7:0] PATTERN = '0;
  logic [3:0] LEN = '0;
  logic [3:0] REPEAT = '0;
  logic       ABORT = 1'b0;

  logic LOAD_READY, SDO, BIT_VALID, FRAME_START, BUSY, DONE;
  logic LOAD_READY0, SDO0, BIT_VALID0, FRAME_START0, BUSY0, DONE0;

  pattern_generator #(.WIDTH(8), .LEN_W(4), .CNT_W(4), .GAP_CYCLES(2), .IDLE_BIT(1'b0)) u_dut (
    .CLK(CLK), .RES(RES), .LOAD_VALID(LOAD_VALID), .LOAD_READY(LOAD_READY),
    .PATTERN(PATTERN), .LEN(LEN), .REPEAT(REPEAT), .ABORT(ABORT),
    .SDO(SDO), .BIT_VALID(BIT_VALID), .FRAME_START(FRAME_START), .BUSY(BUSY), .DONE(DONE)
  );

  pattern_generator #(.WIDTH(8), .LEN_W(4), .CNT_W(4), .GAP_CYCLES(0), .IDLE_BIT(1'b0)) u_dut0 (
    .CLK(CLK), .RES(RES), .LOAD_VALID(LOAD_VALID), .LOAD_READY(LOAD_READY0),
    .PATTERN(PATTERN), .LEN(LEN), .REPEAT(REPEAT), .ABORT(ABORT),
    .SDO(SDO0), .BIT_VALID(BIT_VALID0), .FRAME_START(FRAME_START0), .BUSY(BUSY0), .DONE(DONE0)
  );

  always #5 CLK = ~CLK;

  int n_chk  = 0;
  int n_pass = 0;
  int abort_at = 0;
  int drop_at  = 0;

  logic [31:0] v_sdo, v_bv, v_fs, v_dn, v_by, v_rd;
  logic [31:0] v_sdo0, v_bv0, v_fs0, v_dn0;

  task check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Present a load; the following posedge is the accept edge.
  task start(input logic [7:0] pat, input logic [3:0] len, input logic [3:0] rep, input bit hold);
    PATTERN    = pat;
    LEN        = len;
    REPEAT     = rep;
    LOAD_VALID = 1'b1;
    @(posedge CLK);
    #1;
    if (!hold) LOAD_VALID = 1'b0;
  endtask

  // Sample outputs at the falling edge of cycles 1..n, oldest cycle in the MSB.
  task capture(input int n);
    v_sdo = '0; v_bv = '0; v_fs = '0; v_dn = '0; v_by = '0; v_rd = '0;
    v_sdo0 = '0; v_bv0 = '0; v_fs0 = '0; v_dn0 = '0;
    for (int i = 1; i <= n; i++) begin
      @(negedge CLK);
      v_sdo  = {v_sdo[30:0], SDO};
      v_bv   = {v_bv[30:0], BIT_VALID};
      v_fs   = {v_fs[30:0], FRAME_START};
      v_dn   = {v_dn[30:0], DONE};
      v_by   = {v_by[30:0], BUSY};
      v_rd   = {v_rd[30:0], LOAD_READY};
      v_sdo0 = {v_sdo0[30:0], SDO0};
      v_bv0  = {v_bv0[30:0], BIT_VALID0};
      v_fs0  = {v_fs0[30:0], FRAME_START0};
      v_dn0  = {v_dn0[30:0], DONE0};
      ABORT = (i == abort_at);
      if (i == drop_at) LOAD_VALID = 1'b0;
    end
  endtask

  initial begin
    #1;
    check("reset_state", {SDO, BIT_VALID, FRAME_START, BUSY, DONE, LOAD_READY}, 6'b000001);
    @(negedge CLK);
    RES = 1'b1;

    // Reset mid-frame during bit 3 of an 8-bit send
    start(8'hFF, 4'd8, 4'd1, 1'b0);
    capture(3);
    check("mid_sdo_before", SDO, 1'b1);
    RES = 1'b0;
    #1;
    check("mid_reset_now", {SDO, BIT_VALID, FRAME_START, BUSY, DONE, LOAD_READY}, 6'b000001);
    #1 RES = 1'b1;
    capture(4);
    check("mid_no_done", v_dn, 4'b0000);
    check("mid_no_busy", v_by, 4'b0000);

    // Single frame 1011_0010
    start(8'b1011_0010, 4'd8, 4'd1, 1'b0);
    capture(9);
    check("sf_sdo",  v_sdo, 9'b1011_0010_0);
    check("sf_bv",   v_bv,  9'b1111_1111_0);
    check("sf_fs",   v_fs,  9'b1000_0000_0);
    check("sf_done", v_dn,  9'b0000_0000_1);
    check("sf_busy", v_by,  9'b1111_1111_0);

    // Three 3-bit frames: gap of 2 on u_dut, back-to-back on u_dut0
    start(8'h06, 4'd3, 4'd3, 1'b0);
    capture(14);
    check("gap_sdo",  v_sdo, 14'b11000110001100);
    check("gap_bv",   v_bv,  14'b11100111001110);
    check("gap_fs",   v_fs,  14'b10000100001000);
    check("gap_done", v_dn,  14'b00000000000001);
    check("nogap_sdo",  v_sdo0, 14'b11011011000000);
    check("nogap_bv",   v_bv0,  14'b11111111100000);
    check("nogap_fs",   v_fs0,  14'b10010010000000);
    check("nogap_done", v_dn0,  14'b00000000010000);

    // LEN=12 clamps to 8
    start(8'hC3, 4'd12, 4'd1, 1'b0);
    capture(9);
    check("clamp_sdo",  v_sdo, 9'b1100_0011_0);
    check("clamp_bv",   v_bv,  9'b1111_1111_0);
    check("clamp_done", v_dn,  9'b0000_0000_1);

    // REPEAT=0 sends one frame; upper pattern bits beyond LEN ignored
    start(8'hF5, 4'd3, 4'd0, 1'b0);
    capture(6);
    check("rep0_sdo",  v_sdo, 6'b101000);
    check("rep0_bv",   v_bv,  6'b111000);
    check("rep0_fs",   v_fs,  6'b100000);
    check("rep0_done", v_dn,  6'b000100);

    // LEN=0: nothing sent, DONE one cycle after accept
    start(8'hFF, 4'd0, 4'd2, 1'b0);
    capture(3);
    check("len0_bv",   v_bv, 3'b000);
    check("len0_done", v_dn, 3'b100);
    check("len0_busy", v_by, 3'b000);

    // ABORT during bit 5 of 8
    abort_at = 5;
    start(8'hFF, 4'd8, 4'd1, 1'b0);
    capture(10);
    abort_at = 0;
    check("abort_sdo",  v_sdo, 10'b1111100000);
    check("abort_bv",   v_bv,  10'b1111100000);
    check("abort_busy", v_by,  10'b1111100000);
    check("abort_done", v_dn,  10'b0000000000);

    // ABORT in IDLE blocks a load
    ABORT      = 1'b1;
    LOAD_VALID = 1'b1;
    PATTERN    = 8'hFF;
    LEN        = 4'd8;
    REPEAT     = 4'd1;
    #1;
    check("abort_idle_rdy", LOAD_READY, 1'b0);
    @(posedge CLK);
    #1;
    LOAD_VALID = 1'b0;
    capture(3);
    check("abort_idle_busy", v_by, 3'b000);
    check("abort_idle_bv",   v_bv, 3'b000);

    // Back-to-back: LOAD_VALID held, second pattern accepted on the DONE edge
    drop_at = 10;
    start(8'hB2, 4'd8, 4'd1, 1'b1);
    PATTERN = 8'hA5;
    capture(18);
    drop_at = 0;
    check("b2b_sdo",  v_sdo, 18'b101100100101001010);
    check("b2b_bv",   v_bv,  18'b111111110111111110);
    check("b2b_fs",   v_fs,  18'b100000000100000000);
    check("b2b_done", v_dn,  18'b000000001000000001);
    check("b2b_rdy",  v_rd,  18'b000000001000000001);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/pattern_generator.md
Name: pattern_generator

Overview:
Serial bit-pattern transmitter: the source end of the single-bit serial stream consumed by the team's pattern-detection logic. It accepts a pattern word, length and frame-repeat count through a valid/ready load handshake, then shifts the pattern out MSB-first, one bit per clock. Optional idle gaps separate repeated frames. Frame-start and done strobes are provided for bench and system sequencing.

Parameters:
WIDTH, 8, maximum pattern length in bits (PATTERN width)
LEN_W, 4, width of LEN field (must hold WIDTH)
CNT_W, 4, width of REPEAT field
GAP_CYCLES, 0, idle cycles inserted between consecutive frames (0 = back-to-back)
IDLE_BIT, 1'b0, value driven on SDO whenever no pattern bit is being sent

Ports:
CLK  input  1  clock; all state updates on rising edge (SDO stable across the falling edge for negedge-sampling receivers)
RES  input  1  asynchronous active-low reset
LOAD_VALID  input  1  load request
LOAD_READY  output  1  generator can accept a load
PATTERN  input  WIDTH  pattern bits; bit LEN-1 sent first, bit 0 last
LEN  input  LEN_W  number of bits per frame
REPEAT  input  CNT_W  number of frames to send
ABORT  input  1  synchronous abort of current transfer
SDO  output  1  serial data out
BIT_VALID  output  1  SDO carries a pattern bit this cycle
FRAME_START  output  1  high with the first bit of each frame
BUSY  output  1  transfer in progress
DONE  output  1  one-cycle pulse after final bit of final frame

Behaviour:
- One clock (CLK, rising edge); reset RES asynchronous, active-low. All outputs registered except LOAD_READY and BUSY, which decode state.
- Reset (RES=0, immediate, any state incl. mid-frame): state IDLE, SDO=IDLE_BIT, BIT_VALID=0, FRAME_START=0, DONE=0, BUSY=0, LOAD_READY=1, internal counters 0, pattern register 0.
- States: IDLE, SHIFT, GAP.
- LOAD_READY = (state==IDLE) && !ABORT. BUSY = (state!=IDLE).
- Accept: rising edge with LOAD_VALID && LOAD_READY captures PATTERN, LEN, REPEAT; inputs ignored at all other times.
- Clamping at capture: LEN>WIDTH -> WIDTH; REPEAT==0 -> 1. LEN==0 -> no bits sent, stay IDLE, DONE pulses on the next cycle.
- Latency: first bit on SDO in the cycle following the accept edge (one cycle). Each bit held exactly one cycle. BIT_VALID=1 for every pattern bit. FRAME_START=1 only on the first bit of each frame.
- SHIFT: bit index counts LEN-1 down to 0.
  - After bit 0, if frames remain and GAP_CYCLES>0 -> GAP.
  - If frames remain and GAP_CYCLES==0 -> first bit of next frame in the very next cycle.
  - If last frame -> IDLE.
- GAP: exactly GAP_CYCLES cycles with SDO=IDLE_BIT, BIT_VALID=0, then SHIFT with FRAME_START.
- Completion: DONE=1 for exactly one cycle, the cycle after the last bit. In that cycle SDO=IDLE_BIT and BIT_VALID=0. State is IDLE, so a load may be accepted on that edge, giving back-to-back transfers with no extra idle cycle.
- ABORT (priority over load and shifting): in SHIFT/GAP, the next edge returns to IDLE with SDO=IDLE_BIT and BIT_VALID=0. No DONE pulse. ABORT in IDLE blocks acceptance.
- Total busy cycles for a transfer = REPEAT*LEN + (REPEAT-1)*GAP_CYCLES.
- Frame counter and bit counter never wrap: maximum REPEAT=2^CNT_W-1 frames.

Test Plan:
- Reset mid-frame: assert RES=0 during bit 3 of an 8-bit send -> SDO=IDLE_BIT, BUSY=0, LOAD_READY=1 immediately (before next edge), no DONE.
- Single frame: PATTERN=8'b1011_0010, LEN=8, REPEAT=1 -> SDO=1,0,1,1,0,0,1,0 on cycles 1..8 after accept; FRAME_START only on cycle 1; DONE on cycle 9; BUSY cycles 1..8.
- Short repeated frames with gap: GAP_CYCLES=2, PATTERN=8'h06, LEN=3, REPEAT=3 -> 1,1,0,g,g,1,1,0,g,g,1,1,0 (g=IDLE_BIT, BIT_VALID=0); three FRAME_START pulses; DONE at cycle 14.
- Clamp and degenerate cases: LEN=12 sends 8 bits; REPEAT=0 sends one frame; LEN=0 -> no BIT_VALID, DONE one cycle after accept.
- ABORT at bit 5 of 8: SDO=IDLE_BIT from the next cycle, no DONE. ABORT plus LOAD_VALID in IDLE -> load not accepted (LOAD_READY=0).
- Back-to-back loads: LOAD_VALID held high with a second pattern 8'hA5 -> second transfer accepted on the DONE edge; first bit of 8'hA5 (1) appears in the cycle after DONE; no lost or duplicated bits.
